// File: rtl/ram_burst_master_if.sv
// Bus bundle for ram_burst_master: command channel, write/read data streams,
// status flags and the RAM pins. "master" is the view of the burst engine itself,
// "slave" is the view of whoever sits on the other side (client plus RAM).
interface ram_burst_master_if #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 8
);
    // Command channel
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;

    // Write data stream
    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] wd_data;

    // Read data stream
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;

    // Status
    logic          busy;
    logic          err;

    // RAM pins
    logic          mem_wr;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_data;

    modport master (
        input  req_valid, req_wr, req_addr, req_len,
        input  wd_valid, wd_data,
        input  rd_ready,
        input  mem_data,
        output req_ready,
        output wd_ready,
        output rd_valid, rd_data, rd_last,
        output busy, err,
        output mem_wr, mem_address, mem_din
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_len,
        output wd_valid, wd_data,
        output rd_ready,
        output mem_data,
        input  req_ready,
        input  wd_ready,
        input  rd_valid, rd_data, rd_last,
        input  busy, err,
        input  mem_wr, mem_address, mem_din
    );
endinterface

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst read/write initiator for a single-port synchronous RAM
// with one cycle of registered read latency.
// Build option: define RAM_BURST_BOUNDARY_CHECK_EN to reject (err pulse, no access)
// any command whose burst would run past the top address; otherwise bursts wrap
// modulo 2^AW and err is tied low.
module ram_burst_master #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_burst_master_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain
    } state_e;

    state_e state_q, state_d;

    // Burst bookkeeping
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW-1:0] remaining_q, remaining_d;

    // One read is outstanding in the RAM; its data lands in the FIFO next cycle
    logic in_flight_q, in_flight_d;
    logic in_flight_last_q, in_flight_last_d;

    // Two-entry read output FIFO (data plus end-of-burst marker)
    logic [DW-1:0] fifo_data_q [2];
    logic [1:0]    fifo_last_q;
    logic          fifo_rptr_q;
    logic          fifo_wptr_q;
    logic [1:0]    fifo_cnt_q;

    logic       accept;
    logic       cmd_bad;
    logic       start;
    logic       wr_beat;
    logic       issue;
    logic       push;
    logic       pop;
    logic [1:0] occ_after_pop;

`ifdef RAM_BURST_BOUNDARY_CHECK_EN
    logic [AW:0] end_sum;
    logic        err_q;

    // A carry out of addr+len means the burst would cross the top of memory
    assign end_sum = {1'b0, bus.req_addr} + {1'b0, bus.req_len};
    assign cmd_bad = end_sum[AW];
`else
    assign cmd_bad = 1'b0;
`endif

    assign accept  = bus.req_valid & bus.req_ready;
    assign start   = accept & ~cmd_bad;
    assign wr_beat = (state_q == StWrite) & bus.wd_valid;
    assign push    = in_flight_q;
    assign pop     = bus.rd_valid & bus.rd_ready;

    // Slots still claimed after this edge; counting the pop keeps a full-rate
    // stream bubble-free while never letting more than two beats be outstanding.
    assign occ_after_pop = fifo_cnt_q + {1'b0, in_flight_q} - {1'b0, pop};
    assign issue         = (state_q == StRead) && (occ_after_pop < 2'd2);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = bus.req_wr ? StWrite : StRead;
                end
            end
            StWrite: begin
                if (wr_beat && (remaining_q == '0)) begin
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (issue && (remaining_q == '0)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!in_flight_q && (fifo_cnt_q == 2'd0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state and datapath registers
    always_comb begin
        // Gated by rst_n so the command channel is closed while reset is held
        bus.req_ready   = rst_n && (state_q == StIdle) && (fifo_cnt_q == 2'd0) && !in_flight_q;
        bus.wd_ready    = (state_q == StWrite);
        bus.mem_wr      = wr_beat;
        bus.mem_address = cur_addr_q;
        bus.mem_din     = (state_q == StWrite) ? bus.wd_data : '0;
        bus.rd_valid    = (fifo_cnt_q != 2'd0);
        bus.rd_data     = fifo_data_q[fifo_rptr_q];
        bus.rd_last     = (fifo_cnt_q != 2'd0) && fifo_last_q[fifo_rptr_q];
        bus.busy        = (state_q != StIdle) || (fifo_cnt_q != 2'd0) || in_flight_q;
`ifdef RAM_BURST_BOUNDARY_CHECK_EN
        bus.err         = err_q;
`else
        bus.err         = 1'b0;
`endif
    end

    // Address / beat-count next state
    always_comb begin
        cur_addr_d       = cur_addr_q;
        remaining_d      = remaining_q;
        in_flight_d      = issue;
        in_flight_last_d = issue && (remaining_q == '0);
        if ((state_q == StIdle) && start) begin
            cur_addr_d  = bus.req_addr;
            remaining_d = bus.req_len;
        end else if (wr_beat || issue) begin
            cur_addr_d  = cur_addr_q + AW'(1);
            remaining_d = remaining_q - AW'(1);
        end
    end

    // Address / beat-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr_q       <= '0;
            remaining_q      <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
        end else begin
            cur_addr_q       <= cur_addr_d;
            remaining_q      <= remaining_d;
            in_flight_q      <= in_flight_d;
            in_flight_last_q <= in_flight_last_d;
        end
    end

    // Read FIFO: captures RAM data one cycle after each issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            fifo_rptr_q    <= 1'b0;
            fifo_wptr_q    <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[fifo_wptr_q] <= bus.mem_data;
                fifo_last_q[fifo_wptr_q] <= in_flight_last_q;
                fifo_wptr_q              <= ~fifo_wptr_q;
            end
            if (pop) begin
                fifo_rptr_q <= ~fifo_rptr_q;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 2'd1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 2'd1;
            end
        end
    end

`ifdef RAM_BURST_BOUNDARY_CHECK_EN
    // One-cycle error pulse for a handshaken but rejected command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & cmd_bad;
        end
    end
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed self-checking bench for ram_burst_master with a behavioural 64x8 RAM.
module tb_ram_burst_master;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] ram [64];
    logic [DW-1:0] ram_q;
    logic [DW-1:0] exp_mem [64];
    logic [DW-1:0] wbuf [4];

    always #5 clk = ~clk;

    ram_burst_master_if #(.AW(AW), .DW(DW)) bus ();

    ram_burst_master #(.AW(AW), .DW(DW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Synchronous RAM: write on edge with wr high, registered read data
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= DW'(i) ^ 8'h5A;
        end else if (bus.mem_wr) begin
            ram[bus.mem_address] <= bus.mem_din;
        end
        ram_q <= ram[bus.mem_address];
    end
    assign bus.mem_data = ram_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [5:0] addr, input logic [5:0] len);
        int t;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_len   = len;
        t = 0;
        #1;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("req_ready_wait", 32'(t < 50), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // gap_after: beat index preceded by a wd_valid gap (-1 none)
    // abort_after: beat index at which reset is asserted instead (-1 none)
    task automatic write_burst(input logic [5:0] addr, input logic [5:0] len,
                               input int gap_after, input int gap_len, input int abort_after);
        send_cmd(1'b1, addr, len);
        for (int b = 0; b <= int'(len); b++) begin
            if (b == gap_after) begin
                bus.wd_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    #1;
                    check("stall_mem_wr", 32'(bus.mem_wr), 0);
                    check("stall_addr", 32'(bus.mem_address), 32'(6'(addr + 6'(b))));
                    @(negedge clk);
                end
            end
            bus.wd_valid = 1'b1;
            bus.wd_data  = wbuf[b];
            if (b == abort_after) begin
                rst_n = 1'b0;
                #1;
                check("rst_mem_wr", 32'(bus.mem_wr), 0);
                check("rst_req_ready", 32'(bus.req_ready), 0);
                check("rst_busy", 32'(bus.busy), 0);
                check("rst_rd_valid", 32'(bus.rd_valid), 0);
                check("rst_wd_ready", 32'(bus.wd_ready), 0);
                bus.wd_valid = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("rst_release_ready", 32'(bus.req_ready), 1);
                return;
            end
            #1;
            check("wr_wd_ready", 32'(bus.wd_ready), 1);
            check("wr_mem_wr", 32'(bus.mem_wr), 1);
            check("wr_addr", 32'(bus.mem_address), 32'(6'(addr + 6'(b))));
            check("wr_din", 32'(bus.mem_din), 32'(wbuf[b]));
            exp_mem[6'(addr + 6'(b))] = wbuf[b];
            @(negedge clk);
        end
        bus.wd_valid = 1'b0;
        #1;
        check("wr_done_busy", 32'(bus.busy), 0);
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready 1,0,0 repeating
    task automatic read_burst(input logic [5:0] addr, input logic [5:0] len, input int mode);
        int got, cyc, first, last, max_ahead;
        logic [5:0] d;
        got = 0;
        cyc = 0;
        first = -1;
        last = -1;
        max_ahead = 0;
        send_cmd(1'b0, addr, len);
        while (got <= int'(len) && cyc < 400) begin
            bus.rd_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            d = bus.mem_address - addr - 6'(got);
            if (int'(d) > max_ahead) max_ahead = int'(d);
            if (bus.rd_valid && first < 0) first = cyc;
            if (bus.rd_valid && bus.rd_ready) begin
                check("rd_data", 32'(bus.rd_data), 32'(exp_mem[6'(addr + 6'(got))]));
                check("rd_last", 32'(bus.rd_last), 32'(got == int'(len)));
                last = cyc;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.rd_ready = 1'b0;
        check("rd_count", 32'(got), 32'(int'(len) + 1));
        check("rd_latency", 32'(first), 2);
        check("rd_ahead_le2", 32'(max_ahead <= 2), 1);
        if (mode == 0) check("rd_no_bubble", 32'(last - first), 32'(len));
        @(negedge clk);
        #1;
        check("rd_done_busy", 32'(bus.busy), 0);
        check("rd_done_valid", 32'(bus.rd_valid), 0);
    endtask

    initial begin
        int errs;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.rd_ready  = 1'b0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 8'(i) ^ 8'h5A;

        // Reset values
        repeat (2) @(negedge clk);
        preload = 1'b0;
        #1;
        check("reset_req_ready", 32'(bus.req_ready), 0);
        check("reset_mem_wr", 32'(bus.mem_wr), 0);
        check("reset_mem_address", 32'(bus.mem_address), 0);
        check("reset_mem_din", 32'(bus.mem_din), 0);
        check("reset_wd_ready", 32'(bus.wd_ready), 0);
        check("reset_rd_valid", 32'(bus.rd_valid), 0);
        check("reset_rd_last", 32'(bus.rd_last), 0);
        check("reset_rd_data", 32'(bus.rd_data), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_err", 32'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", 32'(bus.req_ready), 1);

        // Write then read back at full rate
        wbuf = '{8'h11, 8'h22, 8'h33, 8'h44};
        write_burst(6'h10, 6'd3, -1, 0, -1);
        read_burst(6'h10, 6'd3, 0);

        // Single beat
        read_burst(6'h12, 6'd0, 0);

        // Top-of-memory burst
        wbuf = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
`ifdef RAM_BURST_BOUNDARY_CHECK_EN
        errs = 0;
        bus.wd_valid = 1'b1;
        bus.wd_data  = 8'hA0;
        send_cmd(1'b1, 6'h3E, 6'd3);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.err) errs++;
            check("bnd_wd_ready", 32'(bus.wd_ready), 0);
            check("bnd_mem_wr", 32'(bus.mem_wr), 0);
            @(negedge clk);
        end
        bus.wd_valid = 1'b0;
        check("bnd_err_pulses", 32'(errs), 1);
        check("bnd_busy", 32'(bus.busy), 0);
        read_burst(6'h3C, 6'd3, 0);
        read_burst(6'h00, 6'd1, 0);
`else
        errs = 0;
        write_burst(6'h3E, 6'd3, -1, 0, -1);
        check("wrap_err", 32'(bus.err), 32'(errs));
        read_burst(6'h3E, 6'd3, 0);
`endif

        // Write with a 5-cycle wd_valid gap
        wbuf = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        write_burst(6'h30, 6'd3, 1, 5, -1);
        read_burst(6'h30, 6'd3, 0);

        // Back-pressured read
        read_burst(6'h00, 6'd7, 1);

        // Reset in the middle of a write burst
        wbuf = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        write_burst(6'h20, 6'd3, -1, 0, 2);
        read_burst(6'h20, 6'd3, 0);

        // Whole memory
        read_burst(6'h00, 6'd63, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
